// File: rtl/or_gate_bist_analyzer.sv
// or_gate_bist_analyzer
// On-chip stuck-at tester for a two-input OR cell. Each run applies the four
// exhaustive input vectors, holds each one for SETTLE_CYCLES+1 cycles, samples
// the gate output at the end of the hold, then compares the captured responses
// with the OR truth table and decodes the mismatch pattern into a diagnosis.
// Results are held until the next run completes or reset is asserted.

module or_gate_bist_analyzer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_z,
    output logic       test_a,
    output logic       test_b,
    output logic       busy,
    output logic       done,
    output logic [3:0] resp,
    output logic [3:0] mismatch,
    output logic [2:0] fault_count,
    output logic [2:0] diag
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        REPORT = 2'd2
    } state_t;

    // resp[k] of a healthy OR gate, with vector k = {a,b} = k
    localparam logic [3:0]       EXPECTED_RESP = 4'b1110;
    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1:0]       idx, idx_d;
    logic             test_a_d, test_b_d;
    logic             busy_d, done_d;
    logic [3:0]       resp_d, mismatch_d, mismatch_now;
    logic [2:0]       fault_count_d, diag_d;

    // Number of set bits in a 4-bit mismatch pattern (0..4)
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Single-fault signatures of the OR cell; anything else is unclassified
    function automatic logic [2:0] decode_diag(input logic [3:0] m);
        case (m)
            4'b0000: decode_diag = 3'd0;  // healthy
            4'b0001: decode_diag = 3'd1;  // A, B or Z stuck-at-1
            4'b0010: decode_diag = 3'd2;  // B stuck-at-0
            4'b0100: decode_diag = 3'd3;  // A stuck-at-0
            4'b1110: decode_diag = 3'd4;  // Z stuck-at-0, or A and B both stuck-at-0
            default: decode_diag = 3'd5;  // multiple / unclassified
        endcase
    endfunction

    assign mismatch_now = resp ^ EXPECTED_RESP;

    // Next-state and registered-output logic for the test sequencer
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        idx_d         = idx;
        test_a_d      = test_a;
        test_b_d      = test_b;
        busy_d        = busy;
        done_d        = 1'b0;
        resp_d        = resp;
        mismatch_d    = mismatch;
        fault_count_d = fault_count;
        diag_d        = diag;

        case (state)
            IDLE: begin
                test_a_d = 1'b0;
                test_b_d = 1'b0;
                busy_d   = 1'b0;
                if (start) begin
                    state_d  = APPLY;
                    cnt_d    = '0;
                    idx_d    = '0;
                    test_a_d = 1'b0;
                    test_b_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end

            APPLY: begin
                if (cnt == SETTLE_LAST) begin
                    // End of the hold window: the current vector has settled
                    resp_d[idx] = dut_z;
                    cnt_d       = '0;
                    if (idx != 2'd3) begin
                        idx_d                = idx + 2'd1;
                        {test_a_d, test_b_d} = idx + 2'd1;
                    end else begin
                        state_d  = REPORT;
                        test_a_d = 1'b0;
                        test_b_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            REPORT: begin
                mismatch_d    = mismatch_now;
                fault_count_d = popcount4(mismatch_now);
                diag_d        = decode_diag(mismatch_now);
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end

            default: begin
                state_d  = IDLE;
                test_a_d = 1'b0;
                test_b_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any run without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            test_a      <= 1'b0;
            test_b      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            resp        <= '0;
            mismatch    <= '0;
            fault_count <= '0;
            diag        <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            idx         <= idx_d;
            test_a      <= test_a_d;
            test_b      <= test_b_d;
            busy        <= busy_d;
            done        <= done_d;
            resp        <= resp_d;
            mismatch    <= mismatch_d;
            fault_count <= fault_count_d;
            diag        <= diag_d;
        end
    end

endmodule
